dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
- REQ-001: Parameter XLEN, default 32: data and address width.
- REQ-002: Parameter AW, default 11: word-address width of the data memory (2048 words).
- REQ-003: clk_i  in  1  single clock; all state on rising edge.
- REQ-004: rstn_i  in  1  asynchronous, active-low reset.
- REQ-005: c_req_i / d_req_i  in  1  core / debug requester access request.
- REQ-006: c_we_i / d_we_i  in  1  1 = store, 0 = load.
- REQ-007: c_funct3_i / d_funct3_i  in  3  RV32I size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- REQ-008: c_addr_i / d_addr_i  in  XLEN  byte address.
- REQ-009: c_wdata_i / d_wdata_i  in  XLEN  store data, LSB-justified.
- REQ-010: c_gnt_o / d_gnt_o  out  1  request accepted; one-cycle pulse.
- REQ-011: c_rvalid_o / d_rvalid_o  out  1  response valid; one-cycle pulse.
- REQ-012: c_rdata_o / d_rdata_o  out  XLEN  load result, extended per funct3.
- REQ-013: c_err_o / d_err_o  out  1  misaligned or illegal access; qualified by rvalid.
- REQ-014: mem_en_o, mem_we_o  out  1  memory access strobe and write enable.
- REQ-015: mem_addr_o  out  AW  word address = addr[AW+1:2]; upper bits ignored (wrap).
- REQ-016: mem_be_o  out  4  byte enables; mem_wdata_o  out  XLEN  lane-replicated store data.
- REQ-017: mem_rdata_i  in  XLEN  synchronous read data, valid one cycle after mem_en_o.

Function
- REQ-018: The FSM SHALL have states IDLE, ACCESS and RESP, with transitions IDLE->ACCESS when any request is present, ACCESS->RESP always, and RESP->IDLE always.
- REQ-019: On the IDLE->ACCESS edge, the block SHALL capture the winner's we, funct3, addr and wdata, plus an owner bit; the memory port is driven only from these captured registers.
- REQ-020: Latency: a request sampled at edge N SHALL produce gnt in cycle N+1 (ACCESS), then rvalid in cycle N+2 (RESP), then IDLE in cycle N+3.
- REQ-021: gnt_o SHALL equal (state==ACCESS && owner matches); rvalid_o SHALL equal (state==RESP && owner matches); the non-owner's outputs SHALL stay 0.
- REQ-022: A requester SHALL hold req and its fields stable until gnt; req during ACCESS or RESP is ignored until IDLE.
- REQ-023: With a single request, that requester SHALL be granted; with simultaneous requests, the requester not granted last SHALL win (round-robin last_gnt register).
- REQ-024: mem_en_o SHALL be 1 only in ACCESS and only for legal accesses.
- REQ-025: Byte enables: B/BU SHALL use 0001<<addr[1:0]; H/HU SHALL use 0011<<{addr[1],1'b0}; W SHALL use 1111.
- REQ-026: Store data: byte stores SHALL replicate wdata[7:0] into all four lanes, half stores SHALL replicate wdata[15:0] into both halves, and word stores SHALL pass wdata unchanged.
- REQ-027: Load data: the selected lane SHALL be shifted to the LSB; B/H SHALL be sign-extended and BU/HU/W zero-extended; rdata SHALL be 0 for stores.
- REQ-028: An access SHALL be illegal if it is a misaligned half (addr[0]=1), a misaligned word (addr[1:0]!=0), has funct3 011/110/111, or is a store with funct3[2]=1.
- REQ-029: An illegal access SHALL still pass through ACCESS (gnt=1, mem_en_o=0) and RESP (rvalid=1, err=1, rdata=0), and no memory write SHALL occur.

Reset
- REQ-030: rstn_i low SHALL immediately force IDLE, all outputs 0, last_gnt = debug (so the core wins the first tie), and captured registers to 0.
- REQ-031: Reset asserted during ACCESS SHALL abort the access: mem_en_o drops asynchronously, and no rvalid follows.

Structure
- REQ-032: riscv_pkg SHALL hold XLEN, the funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the arb_state_e enum {IDLE, ACCESS, RESP}.
- REQ-033: A combinational sub-module dmem_lane_align SHALL generate be, replicated wdata, load extension and the illegal flag.
- REQ-034: Arbitration and FSM logic SHALL reside in dmem_arbiter.

Verification
- REQ-035: Core SW, addr 0x10, wdata 0xDEADBEEF -> ACCESS: mem_addr 4, be 1111, we 1; RESP: c_rvalid=1, err 0.
- REQ-036: Core LB at addr 0x13 with mem_rdata 0x80FFFFFF -> be 1000, c_rdata 0xFFFFFF80; LBU on the same data -> 0x00000080.
- REQ-037: Core and debug both request for three back-to-back rounds from reset -> grant order core, debug, core, each a 3-cycle transaction.
- REQ-038: Debug LW at addr 0x6 -> d_gnt=1, mem_en_o=0; RESP: d_err=1, d_rdata 0.
- REQ-039: Core SH at addr 0x2, wdata 0x1234ABCD -> be 1100, mem_wdata 0xABCDABCD.
- REQ-040: rstn_i pulsed low during ACCESS of a store -> mem_en_o falls immediately, no rvalid, state IDLE, core wins the next tie.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I data-memory constants: load/store size codes and the arbiter state type.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for one captured access: byte enables, store replication, load extension, legality.
// Purely combinational, zero latency; no flow control of its own.
module dmem_lane_align #(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  input  logic            we_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            illegal_o
);
  import riscv_pkg::*;

  logic [XLEN-1:0] shifted;

  always_comb begin
    be_o      = 4'b0000;
    wdata_o   = wdata_i;
    rdata_o   = '0;
    illegal_o = 1'b0;
    // Legal halves have addr[0]=0, so one byte-granular shift serves every size.
    shifted   = rdata_i >> {addr_lo_i, 3'b000};

    case (funct3_i)
      F3_B, F3_BU: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {(XLEN/8){wdata_i[7:0]}};
      end
      F3_H, F3_HU: begin
        be_o      = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o   = {(XLEN/16){wdata_i[15:0]}};
        illegal_o = addr_lo_i[0];
      end
      F3_W: begin
        be_o      = 4'b1111;
        illegal_o = (addr_lo_i != 2'b00);
      end
      default: illegal_o = 1'b1;
    endcase

    if (we_i && funct3_i[2]) illegal_o = 1'b1;

    case (funct3_i)
      F3_B:    rdata_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_BU:   rdata_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_H:    rdata_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_HU:   rdata_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
      F3_W:    rdata_o = shifted;
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one sync data-memory port between core and debug requesters.
// Grant one cycle after request, response the cycle after; requesters hold until gnt.
module dmem_arbiter #(
  parameter int XLEN = 32,
  parameter int AW   = 11
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            c_req_i,
  input  logic            c_we_i,
  input  logic [2:0]      c_funct3_i,
  input  logic [XLEN-1:0] c_addr_i,
  input  logic [XLEN-1:0] c_wdata_i,
  output logic            c_gnt_o,
  output logic            c_rvalid_o,
  output logic [XLEN-1:0] c_rdata_o,
  output logic            c_err_o,
  input  logic            d_req_i,
  input  logic            d_we_i,
  input  logic [2:0]      d_funct3_i,
  input  logic [XLEN-1:0] d_addr_i,
  input  logic [XLEN-1:0] d_wdata_i,
  output logic            d_gnt_o,
  output logic            d_rvalid_o,
  output logic [XLEN-1:0] d_rdata_o,
  output logic            d_err_o,
  output logic            mem_en_o,
  output logic            mem_we_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [3:0]      mem_be_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic [XLEN-1:0] mem_rdata_i
);
  import riscv_pkg::*;

  arb_state_e      state_q, state_d;
  logic            last_gnt_q, last_gnt_d;   // 1 = debug was granted last
  logic            owner_q, owner_d;         // 1 = debug owns the access
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [AW+1:0]   addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;

  logic            win_dbg;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata_rep, rdata_ext, resp_rdata;
  logic            illegal;
  logic            unused_addr_hi;

  // Address bits above the memory span wrap silently.
  assign unused_addr_hi = ^{c_addr_i[XLEN-1:AW+2], d_addr_i[XLEN-1:AW+2]};
  assign win_dbg        = d_req_i & (~c_req_i | ~last_gnt_q);

  dmem_lane_align #(.XLEN(XLEN)) u_align (
    .funct3_i  (f3_q),
    .addr_lo_i (addr_q[1:0]),
    .we_i      (we_q),
    .wdata_i   (wdata_q),
    .rdata_i   (mem_rdata_i),
    .be_o      (be),
    .wdata_o   (wdata_rep),
    .rdata_o   (rdata_ext),
    .illegal_o (illegal)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      f3_q       <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      f3_q       <= f3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    owner_d    = owner_q;
    we_d       = we_q;
    f3_d       = f3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    case (state_q)
      IDLE: begin
        if (c_req_i || d_req_i) begin
          state_d    = ACCESS;
          owner_d    = win_dbg;
          last_gnt_d = win_dbg;
          we_d       = win_dbg ? d_we_i     : c_we_i;
          f3_d       = win_dbg ? d_funct3_i : c_funct3_i;
          addr_d     = win_dbg ? d_addr_i[AW+1:0] : c_addr_i[AW+1:0];
          wdata_d    = win_dbg ? d_wdata_i  : c_wdata_i;
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr_o  = addr_q[AW+1:2];
  assign mem_wdata_o = wdata_rep;

  always_comb begin
    c_gnt_o    = 1'b0;
    d_gnt_o    = 1'b0;
    c_rvalid_o = 1'b0;
    d_rvalid_o = 1'b0;
    c_rdata_o  = '0;
    d_rdata_o  = '0;
    c_err_o    = 1'b0;
    d_err_o    = 1'b0;
    mem_en_o   = 1'b0;
    mem_we_o   = 1'b0;
    mem_be_o   = 4'b0000;
    resp_rdata = (illegal || we_q) ? '0 : rdata_ext;
    case (state_q)
      ACCESS: begin
        c_gnt_o  = ~owner_q;
        d_gnt_o  = owner_q;
        mem_en_o = ~illegal;
        mem_we_o = ~illegal & we_q;
        mem_be_o = illegal ? 4'b0000 : be;
      end
      RESP: begin
        c_rvalid_o = ~owner_q;
        d_rvalid_o = owner_q;
        c_err_o    = ~owner_q & illegal;
        d_err_o    = owner_q & illegal;
        c_rdata_o  = owner_q ? '0 : resp_rdata;
        d_rdata_o  = owner_q ? resp_rdata : '0;
      end
      default: ;
    endcase
  end

endmodule
